fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the MIPS CPU. It owns the program counter and the chip-enable.
- Issues single-outstanding requests to instruction memory with a req/ack handshake, tolerating wait states.
- Holds fetched instructions under downstream stall and redirects the PC on branch/jump from later stages.
- Replaces free-running PC increment with a controlled fetch stage feeding IF/ID.

---
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer feeding IF/ID.
// Owns the program counter and the instruction-memory chip enable, issues one
// outstanding req/ack fetch at a time, holds the fetched word while IF/ID is
// stalled and redirects the PC on branch/jump pulses from later stages.
//
// Optional build macro FETCH_TIMEOUT_EN: adds an ack wait counter. After
// TIMEOUT_CYC cycles in REQ without ack, fetch_err is raised (sticky) and the
// fetch is retried at the same pc. Without the macro fetch_err is tied low.
//
// Handshake: imem_req is high exactly while the FSM is in REQ, and imem_addr
// is held stable until the cycle imem_ack is sampled high at a rising clk edge
// (ack in the first req cycle is legal). imem_ack while imem_req is low is
// ignored. inst_valid/inst/inst_pc form a valid-only output that holds while
// stall is high; an instruction is consumed at the first edge with stall low.
module fetch_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ce,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] held_addr;     // address of a request orphaned by a branch
    logic              drop_pending;  // in-flight request's data must be discarded
    logic [ADDR_W-1:0] target;
    logic              timeout_hit;

    // A zero-wait-state TIMEOUT_CYC would time out before any ack could land.
    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("fetch_ctrl: TIMEOUT_CYC must be at least 1");
    end

    // Branch targets are word aligned regardless of what the pipeline sends.
    assign target    = branch_target & ~ADDR_W'(3);

    // While an orphaned request is outstanding the bus keeps its old address;
    // the redirected pc only shows up once that request has been acked.
    assign imem_req  = (state == REQ);
    assign imem_addr = drop_pending ? held_addr : pc;
    assign fsm_state = state;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == REQ) && !imem_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count unacked REQ cycles; raise the sticky error when the budget runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (state == REQ && !imem_ack) begin
            if (timeout_hit) begin
                wait_cnt  <= '0;
                fetch_err <= 1'b1;
            end else begin
                wait_cnt  <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // Fetch FSM: pc, chip enable, request tracking and the IF/ID output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            held_addr    <= '0;
            drop_pending <= 1'b0;
            ce           <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // ce rises once out of reset and stays high; a timeout
                    // also passes through here with ce already set.
                    ce    <= 1'b1;
                    state <= REQ;
                    if (branch_en) begin
                        pc <= target;
                    end
                end

                REQ: begin
                    if (imem_ack) begin
                        drop_pending <= 1'b0;
                        if (branch_en) begin
                            // Redirect wins: the returning word belongs to the
                            // wrong path, fetch again from the target.
                            pc <= target;
                        end else if (!drop_pending) begin
                            inst       <= imem_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + ADDR_W'(4);
                            state      <= HOLD;
                        end
                    end else if (timeout_hit) begin
                        // Abandon the request; retry from pc after one IDLE cycle.
                        if (branch_en) begin
                            pc <= target;
                        end
                        drop_pending <= 1'b0;
                        state        <= IDLE;
                    end else if (branch_en) begin
                        // The request already on the bus must still complete,
                        // so remember its address and drop its data later.
                        pc <= target;
                        if (!drop_pending) begin
                            drop_pending <= 1'b1;
                            held_addr    <= pc;
                        end
                    end
                end

                HOLD: begin
                    if (branch_en) begin
                        inst_valid <= 1'b0;
                        pc         <= target;
                        state      <= REQ;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. A small memory responder inside tick() answers
// requests after a programmable number of wait states, pushes each
// instruction that should reach IF/ID onto exp_q, and pops/compares whenever
// inst_valid rises. Scenario tasks add inline checks on top.
module tb_fetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          branch_en;
    logic [AW-1:0] branch_target;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          ce;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          inst_valid;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          fetch_err;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr;
    int               mem_wait;
    int               mem_cnt;
    bit               mem_hold;
    bit               stray;
    bit               model_drop;
    bit               prev_valid;

    fetch_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ce(ce), .imem_req(imem_req), .imem_addr(imem_addr), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err), .fsm_state(fsm_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // One cycle from negedge to negedge: memory responds, scoreboard compares.
    task automatic tick();
        logic [AW+DW-1:0] e;
        if (imem_req === 1'b1) begin
            n_checks++;
            if (imem_addr !== exp_addr) begin
                n_errors++;
                $display("FAIL req_addr: got %h expected %h", imem_addr, exp_addr);
            end
            if (!mem_hold && mem_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(exp_addr);
                if (!model_drop && !branch_en) begin
                    exp_q.push_back({exp_addr, mem_word(exp_addr)});
                    exp_addr = exp_addr + 32'd4;
                end
                model_drop = 1'b0;
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_cnt++;
                if (branch_en) model_drop = 1'b1;
            end
        end else begin
            imem_ack   = stray;
            imem_rdata = $urandom;
            mem_cnt    = 0;
        end
        @(posedge clk);
        @(negedge clk);
        if (inst_valid === 1'b1 && !prev_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc, inst} !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard: got pc %h inst %h expected pc %h inst %h",
                             inst_pc, inst, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        prev_valid = (inst_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        mem_wait = 0; mem_cnt = 0; mem_hold = 1'b0; stray = 1'b0;
        model_drop = 1'b0; prev_valid = 1'b0; exp_addr = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL rst_ce: got %b expected 0", ce); end
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_errors++; $display("FAIL rst_inst: got %h/%h expected 0/0", inst, inst_pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (ce !== 1'b1) begin n_errors++; $display("FAIL release_ce: got %b expected 1", ce); end
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL release_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_sequential();
        mem_wait = 0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL seq_req[%0d]: got %b expected 1", k, imem_req); end
            tick();
            n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)) begin
                n_errors++; $display("FAIL seq_valid[%0d]: got %b/%h expected 1/%h", k, inst_valid, inst_pc, 32'(4 * k)); end
            n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL seq_hold_req[%0d]: got %b expected 0", k, imem_req); end
            tick();
            n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL seq_consume[%0d]: got %b expected 0", k, inst_valid); end
        end
    endtask

    task automatic test_wait_states();
        mem_wait = 3;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
                n_errors++; $display("FAIL wait_req[%0d]: got req %b valid %b expected 1 0", i, imem_req, inst_valid); end
            tick();
        end
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin
            n_errors++; $display("FAIL wait_valid: got %b/%h expected 1/0000000c", inst_valid, inst_pc); end
        mem_wait = 0;
        tick();
    endtask

    task automatic test_stall();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== mem_word(32'h10) || imem_req !== 1'b0) begin
                n_errors++; $display("FAIL stall_hold[%0d]: got v%b pc %h inst %h req %b expected v1 pc 00000010 inst %h req 0",
                                     i, inst_valid, inst_pc, inst, imem_req, mem_word(32'h10)); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_errors++; $display("FAIL stall_next: got req %b addr %h expected 1 00000014", imem_req, imem_addr); end
    endtask

    task automatic test_branch_inflight();
        mem_wait = 2;
        tick();
        branch_en = 1'b1; branch_target = 32'h103;
        tick();
        branch_en = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_errors++; $display("FAIL inflight_stable: got req %b addr %h expected 1 00000014", imem_req, imem_addr); end
        tick();
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_errors++; $display("FAIL inflight_drop: got v%b req %b addr %h expected v0 req 1 addr 00000100", inst_valid, imem_req, imem_addr); end
        exp_addr = 32'h100;
        mem_wait = 0;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
            n_errors++; $display("FAIL inflight_target: got %b/%h expected 1/00000100", inst_valid, inst_pc); end
        tick();
    endtask

    task automatic test_branch_same_cycle();
        branch_en = 1'b1; branch_target = 32'h200;
        tick();
        branch_en = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_errors++; $display("FAIL same_cycle: got v%b req %b addr %h expected v0 req 1 addr 00000200", inst_valid, imem_req, imem_addr); end
        exp_addr = 32'h200;
    endtask

    task automatic test_branch_hold();
        tick();
        stall = 1'b1; branch_en = 1'b1; branch_target = 32'h302;
        tick();
        stall = 1'b0; branch_en = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_errors++; $display("FAIL hold_branch: got v%b req %b addr %h expected v0 req 1 addr 00000300", inst_valid, imem_req, imem_addr); end
        exp_addr = 32'h300;
    endtask

    task automatic test_back_to_back();
        mem_wait = 5;
        tick();
        branch_en = 1'b1; branch_target = 32'h400;
        tick();
        branch_target = 32'h500;
        tick();
        branch_en = 1'b0;
        n_checks++; if (imem_addr !== 32'h300) begin n_errors++; $display("FAIL b2b_stable: got %h expected 00000300", imem_addr); end
        mem_wait = 0;
        tick();
        n_checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h500) begin
            n_errors++; $display("FAIL b2b_last: got v%b addr %h expected v0 addr 00000500", inst_valid, imem_addr); end
        exp_addr = 32'h500;
    endtask

    task automatic test_wrap();
        branch_en = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_en = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_inst: got %b/%h expected 1/fffffffc", inst_valid, inst_pc); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_errors++; $display("FAIL wrap_addr: got req %b addr %h expected 1 00000000", imem_req, imem_addr); end
    endtask

    task automatic test_stray_ack();
        tick();
        stall = 1'b1; stray = 1'b1;
        repeat (2) tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
            n_errors++; $display("FAIL stray_ack: got v%b pc %h inst %h expected v1 pc 00000000 inst %h", inst_valid, inst_pc, inst, mem_word(32'h0)); end
        stall = 1'b0; stray = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_errors++; $display("FAIL stray_next: got req %b addr %h expected 1 00000004", imem_req, imem_addr); end
    endtask

    task automatic test_ack_withheld();
        mem_hold = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            n_errors++; $display("FAIL timeout_early: got err %b req %b expected 0 1", fetch_err, imem_req); end
        tick();
        n_checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ce !== 1'b1) begin
            n_errors++; $display("FAIL timeout_hit: got err %b req %b ce %b expected 1 0 1", fetch_err, imem_req, ce); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_err !== 1'b1) begin
            n_errors++; $display("FAIL timeout_retry: got req %b addr %h err %b expected 1 00000004 1", imem_req, imem_addr, fetch_err); end
`else
        repeat (20) tick();
        n_checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_errors++; $display("FAIL withheld: got err %b req %b addr %h expected 0 1 00000004", fetch_err, imem_req, imem_addr); end
`endif
        mem_hold = 1'b0;
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
            n_errors++; $display("FAIL withheld_done: got %b/%h expected 1/00000004", inst_valid, inst_pc); end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_wait = 3;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || ce !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || imem_addr !== 32'h0) begin
            n_errors++; $display("FAIL async_rst: got req %b ce %b v %b err %b addr %h expected 0 0 0 0 00000000",
                                 imem_req, ce, inst_valid, fetch_err, imem_addr); end
        @(negedge clk);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        n_checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_ack_ignored: got req %b v %b expected 0 0", imem_req, inst_valid); end
        rst_n = 1'b1; exp_addr = 32'h0; mem_cnt = 0; model_drop = 1'b0; prev_valid = 1'b0; mem_wait = 0;
        tick();
        n_checks++; if (ce !== 1'b1 || imem_req !== 1'b1) begin
            n_errors++; $display("FAIL rerelease: got ce %b req %b expected 1 1", ce, imem_req); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_errors++; $display("FAIL rerelease_inst: got %b/%h expected 1/00000000", inst_valid, inst_pc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_branch_inflight();
        test_branch_same_cycle();
        test_branch_hold();
        test_back_to_back();
        test_wrap();
        test_stray_ack();
        test_ack_withheld();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
